// File: rtl/array_pack_buffer_pkg.sv
// Shared types and sizing helpers for the array pack buffer and its controller.
package array_pkg;

    typedef enum logic {FILL, FULL} pack_state_t;

    localparam int unsigned MAX_DEPTH = 16;

    // Width needed to hold a count of 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/array_pack_buffer_ctrl.sv
// Frame controller: FILL/FULL state machine and fill counter, producing the
// handshake outputs and the element write strobe/index for the storage array.
module array_pack_ctrl
    import array_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          out_valid,
    output logic          wr_en,
    output logic [CW-1:0] wr_idx,
    output logic [CW-1:0] fill_cnt
);

    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    pack_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_valid = (state_q == FULL);
        in_ready  = !clr && ((state_q == FILL) || out_ready);
        in_acc    = in_valid && in_ready;
        wr_en     = in_acc;
        // A back-to-back sample while FULL always starts the next frame at slot 0.
        wr_idx    = (state_q == FULL) ? '0 : cnt_q;

        if (clr) begin
            state_d = FILL;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (in_acc) begin
                        if (cnt_q == LAST_IDX) begin
                            state_d = FULL;
                            cnt_d   = FULL_CNT;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (in_acc) begin
                            state_d = (DEPTH == 1) ? FULL : FILL;
                            cnt_d   = (DEPTH == 1) ? FULL_CNT : CW'(1);
                        end else begin
                            state_d = FILL;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign fill_cnt = cnt_q;

endmodule

// File: rtl/array_pack_buffer.sv
// Collects DEPTH samples into an unpacked frame and presents it both as an
// array and as a packed vector until downstream accepts it.
module array_pack_buffer
    import array_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data [DEPTH-1:0],
    output logic [DEPTH*WIDTH-1:0]     out_packed,
    output logic [$clog2(DEPTH+1)-1:0] fill_cnt
);

    localparam int unsigned CW = cnt_width(DEPTH);

    typedef logic [WIDTH-1:0] elem_t;

    elem_t         elem_q [DEPTH];
    elem_t         elem_d [DEPTH];
    logic          wr_en;
    logic [CW-1:0] wr_idx;
    logic [CW-1:0] cnt;

    array_pack_ctrl #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .fill_cnt  (cnt)
    );

    always_comb begin
        elem_d = elem_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (wr_en && (wr_idx == CW'(i))) begin
                elem_d[i] = in_data;
            end
        end
    end

    // Storage is wiped on abort as well as reset so a cleared frame reads as zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            elem_q <= '{default: '0};
        end else begin
            elem_q <= elem_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_out
        assign out_data[gi]                  = elem_q[gi];
        assign out_packed[gi*WIDTH +: WIDTH] = elem_q[gi];
    end

    assign fill_cnt = cnt;

endmodule

// File: tb/tb_array_pack_buffer.sv
// Self-checking bench: directed cases on WIDTH=1/DEPTH=2 and WIDTH=4/DEPTH=1,
// plus randomized traffic on WIDTH=8/DEPTH=5 against a queue-style model.
module tb_array_pack_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // DUT a: WIDTH=1, DEPTH=2
    logic       a_rst, a_clr, a_iv, a_ir, a_id, a_ov, a_or;
    logic [0:0] a_od [1:0];
    logic [1:0] a_op, a_fc;

    array_pack_buffer #(.WIDTH(1), .DEPTH(2)) u_a (
        .clk(clk), .rst(a_rst), .clr(a_clr), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .out_packed(a_op), .fill_cnt(a_fc)
    );

    // DUT b: WIDTH=4, DEPTH=1
    logic       b_rst, b_clr, b_iv, b_ir, b_ov, b_or;
    logic [3:0] b_id;
    logic [3:0] b_od [0:0];
    logic [3:0] b_op;
    logic [0:0] b_fc;

    array_pack_buffer #(.WIDTH(4), .DEPTH(1)) u_b (
        .clk(clk), .rst(b_rst), .clr(b_clr), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .out_packed(b_op), .fill_cnt(b_fc)
    );

    // DUT c: WIDTH=8, DEPTH=5
    logic        c_rst, c_clr, c_iv, c_ir, c_ov, c_or;
    logic [7:0]  c_id;
    logic [7:0]  c_od [4:0];
    logic [39:0] c_op;
    logic [2:0]  c_fc;

    array_pack_buffer #(.WIDTH(8), .DEPTH(5)) u_c (
        .clk(clk), .rst(c_rst), .clr(c_clr), .in_valid(c_iv), .in_ready(c_ir),
        .in_data(c_id), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
        .out_packed(c_op), .fill_cnt(c_fc)
    );

    // Reference model for DUT c: number of samples held plus the element values.
    int         m_n;
    logic [7:0] m_mem [5];

    function automatic logic [39:0] model_packed();
        logic [39:0] p;
        for (int i = 0; i < 5; i++) p[i*8 +: 8] = m_mem[i];
        return p;
    endfunction

    initial begin
        a_rst = 1; a_clr = 0; a_iv = 1; a_id = 1; a_or = 0;
        b_rst = 1; b_clr = 0; b_iv = 0; b_id = 0; b_or = 0;
        c_rst = 1; c_clr = 0; c_iv = 0; c_id = 0; c_or = 0;
        m_n = 0;
        for (int i = 0; i < 5; i++) m_mem[i] = '0;
        tick; tick;
        a_rst = 0; a_iv = 0; b_rst = 0; c_rst = 0;
        #1;
        check("rst_ov", a_ov, 0);
        check("rst_fc", a_fc, 0);
        check("rst_op", a_op, 0);
        check("rst_ir", a_ir, 1);
        $display("reset: ov=%0d fc=%0d op=%b ir=%0d", a_ov, a_fc, a_op, a_ir);

        // Basic frame: samples 1 then 0 with downstream stalled
        a_iv = 1; a_id = 1; tick;
        check("fill1_fc", a_fc, 1);
        check("fill1_ov", a_ov, 0);
        a_id = 0; tick;
        a_iv = 0; #1;
        check("frame_ov", a_ov, 1);
        check("frame_od0", a_od[0], 1);
        check("frame_od1", a_od[1], 0);
        check("frame_op", a_op, 2'b01);
        check("frame_ir", a_ir, 0);
        check("frame_fc", a_fc, 2);
        $display("frame: op=%b fc=%0d", a_op, a_fc);

        // Backpressure: offered samples must be refused, frame held
        a_iv = 1; a_id = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("hold_op", a_op, 2'b01);
            check("hold_fc", a_fc, 2);
            check("hold_ov", a_ov, 1);
        end

        // Release with a simultaneous new sample
        a_or = 1; a_id = 1; #1;
        check("rel_ir", a_ir, 1);
        tick;
        a_iv = 0; a_or = 0; #1;
        check("rel_ov", a_ov, 0);
        check("rel_fc", a_fc, 1);
        check("rel_od0", a_od[0], 1);
        $display("release: fc=%0d od0=%0d", a_fc, a_od[0]);

        a_clr = 1; tick; a_clr = 0; #1;
        check("clr_fc", a_fc, 0);
        check("clr_op", a_op, 0);

        // Streaming 1,1,0,1 with out_ready held high
        a_or = 1; a_iv = 1; a_id = 1; tick;
        a_id = 1; tick;
        check("s1_ov", a_ov, 1);
        check("s1_op", a_op, 2'b11);
        a_id = 0; #1;
        check("s1_ir", a_ir, 1);
        tick;
        check("s2_ov", a_ov, 0);
        check("s2_fc", a_fc, 1);
        a_id = 1; tick;
        check("s3_ov", a_ov, 1);
        check("s3_op", a_op, 2'b10);
        a_iv = 0; tick;
        check("s4_ov", a_ov, 0);
        check("s4_fc", a_fc, 0);
        $display("stream: frames 11 and 10 delivered");

        // Abort mid-frame; the sample offered during clr is dropped
        a_or = 0; a_iv = 1; a_id = 1; tick;
        check("ab_fc1", a_fc, 1);
        a_clr = 1; #1;
        check("ab_ir", a_ir, 0);
        tick;
        a_clr = 0;
        check("ab_fc0", a_fc, 0);
        check("ab_op", a_op, 0);
        a_id = 0; tick;
        a_id = 1; tick;
        a_iv = 0; #1;
        check("ab_ov", a_ov, 1);
        check("ab_frame", a_op, 2'b10);
        $display("abort: fresh frame op=%b", a_op);

        // rst together with clr while FULL
        a_rst = 1; a_clr = 1; a_or = 1; a_iv = 1; tick;
        a_rst = 0; a_clr = 0; a_or = 0; a_iv = 0; #1;
        check("prec_ov", a_ov, 0);
        check("prec_fc", a_fc, 0);
        check("prec_op", a_op, 0);

        // DEPTH=1: each sample is a complete frame
        b_iv = 1; b_id = 4'hA; tick;
        b_iv = 0; #1;
        check("d1_ov", b_ov, 1);
        check("d1_op", b_op, 4'hA);
        check("d1_fc", b_fc, 1);
        check("d1_ir", b_ir, 0);
        b_or = 1; b_iv = 1; b_id = 4'h5; #1;
        check("d1_ir2", b_ir, 1);
        tick;
        check("d1_b2b_ov", b_ov, 1);
        check("d1_b2b_op", b_op, 4'h5);
        b_iv = 0; tick;
        check("d1_end_ov", b_ov, 0);
        check("d1_end_fc", b_fc, 0);
        check("d1_end_op", b_od[0], 4'h5);
        b_or = 0;
        $display("depth1: back-to-back frames A and 5");

        // Randomized traffic on DEPTH=5
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic exp_ir, acc_in, acc_out;
            c_rst = ($urandom_range(63) == 0);
            c_clr = ($urandom_range(15) == 0);
            c_iv  = ($urandom_range(3) != 0);
            c_or  = ($urandom_range(2) == 0);
            c_id  = 8'($urandom);
            #1;
            exp_ir = !c_clr && ((m_n < 5) || c_or);
            check("rnd_ir", c_ir, exp_ir);
            if (c_rst || c_clr) begin
                m_n = 0;
                for (int i = 0; i < 5; i++) m_mem[i] = '0;
            end else begin
                acc_in  = c_iv && exp_ir;
                acc_out = (m_n == 5) && c_or;
                if (acc_out) m_n = 0;
                if (acc_in) begin
                    m_mem[m_n] = c_id;
                    m_n++;
                end
            end
            tick;
            check("rnd_ov", c_ov, (m_n == 5));
            check("rnd_fc", c_fc, m_n);
            check("rnd_op", c_op, model_packed());
            check("rnd_od0", c_od[0], m_mem[0]);
            $display("rnd %0d: rst=%0d clr=%0d iv=%0d or=%0d fc=%0d ov=%0d", cyc,
                     c_rst, c_clr, c_iv, c_or, c_fc, c_ov);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
